// File: rtl/pong_pkg.sv
// Shared constants and types for the Pong renderer: default geometry,
// 12-bit colour type with channel helpers, and post-reset object positions.
package pong_pkg;

  // Default 640x480 timing and object geometry
  localparam int unsigned DefHOfs        = 144;
  localparam int unsigned DefVOfs        = 35;
  localparam int unsigned DefHActive     = 640;
  localparam int unsigned DefVActive     = 480;
  localparam int unsigned DefBorder      = 10;
  localparam int unsigned DefNetW        = 10;
  localparam int unsigned DefPaddleLen   = 50;
  localparam int unsigned DefPaddleW     = 10;
  localparam int unsigned DefPaddleInset = 40;
  localparam int unsigned DefBallSide    = 10;
  localparam int unsigned DefFlashFrames = 30;

  // Packed {r, g, b}, 4 bits per channel
  typedef logic [11:0] rgb12_t;

  localparam rgb12_t DefColFg    = 12'hFFF;
  localparam rgb12_t DefColBall  = 12'hFF0;
  localparam rgb12_t DefColFlash = 12'hF00;

  // Active positions loaded by reset (roughly screen centre)
  localparam logic [9:0] RstPaddle = 10'd215;
  localparam logic [9:0] RstBallX  = 10'd315;
  localparam logic [9:0] RstBallY  = 10'd235;

  function automatic logic [3:0] rgb_r(rgb12_t c);
    return c[11:8];
  endfunction

  function automatic logic [3:0] rgb_g(rgb12_t c);
    return c[7:4];
  endfunction

  function automatic logic [3:0] rgb_b(rgb12_t c);
    return c[3:0];
  endfunction

endpackage

// File: rtl/pong_rect_hit.sv
// Combinational half-open rectangle test: hit when x in [x0, x0+w) and
// y in [y0, y0+h). All arithmetic is 12-bit.
module pong_rect_hit (
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [11:0] x0,
  input  logic [11:0] y0,
  input  logic [11:0] w,
  input  logic [11:0] h,
  output logic        hit
);

  logic [11:0] x1;
  logic [11:0] y1;

  assign x1 = x0 + w;
  assign y1 = y0 + h;

  // Inclusive start, exclusive end on both axes
  always_comb begin
    hit = (x >= x0) && (x < x1) && (y >= y0) && (y < y1);
  end

endmodule

// File: rtl/pong_renderer.sv
// Two-stage registered Pong pixel generator with frame-synchronous position
// updates. Optional goal flash of the border is enabled by defining
// PONG_GOAL_FLASH_EN.
module pong_renderer
  import pong_pkg::*;
#(
  parameter int unsigned H_OFS        = DefHOfs,
  parameter int unsigned V_OFS        = DefVOfs,
  parameter int unsigned H_ACTIVE     = DefHActive,
  parameter int unsigned V_ACTIVE     = DefVActive,
  parameter int unsigned BORDER       = DefBorder,
  parameter int unsigned NET_W        = DefNetW,
  parameter int unsigned PADDLE_LEN   = DefPaddleLen,
  parameter int unsigned PADDLE_W     = DefPaddleW,
  parameter int unsigned PADDLE_INSET = DefPaddleInset,
  parameter int unsigned BALL_SIDE    = DefBallSide,
  parameter rgb12_t      COL_FG       = DefColFg,
  parameter rgb12_t      COL_BALL     = DefColBall,
  parameter rgb12_t      COL_FLASH    = DefColFlash,
  parameter int unsigned FLASH_FRAMES = DefFlashFrames
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [11:0] h_cnt,
  input  logic [11:0] v_cnt,
  input  logic       enable,
  input  logic       frame_start,
  input  logic       pos_valid,
  output logic       pos_ready,
  input  logic [9:0] paddle_1,
  input  logic [9:0] paddle_2,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       goal,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       pix_valid
);

  localparam logic [11:0] HOfs     = 12'(H_OFS);
  localparam logic [11:0] VOfs     = 12'(V_OFS);
  localparam logic [11:0] XLo      = 12'(H_OFS);
  localparam logic [11:0] XHi      = 12'(H_OFS + H_ACTIVE);
  localparam logic [11:0] YLo      = 12'(V_OFS);
  localparam logic [11:0] YHi      = 12'(V_OFS + V_ACTIVE);
  localparam logic [11:0] XInLo    = 12'(H_OFS + BORDER);
  localparam logic [11:0] XInHi    = 12'(H_OFS + H_ACTIVE - BORDER);
  localparam logic [11:0] YInLo    = 12'(V_OFS + BORDER);
  localparam logic [11:0] YInHi    = 12'(V_OFS + V_ACTIVE - BORDER);
  localparam logic [11:0] NetX     = 12'(H_OFS + H_ACTIVE / 2 - NET_W / 2);
  localparam logic [11:0] LPadX    = 12'(H_OFS + PADDLE_INSET);
  localparam logic [11:0] RPadX    = 12'(H_OFS + H_ACTIVE - PADDLE_INSET - PADDLE_W);
  localparam logic [11:0] NetW     = 12'(NET_W);
  localparam logic [11:0] VAct     = 12'(V_ACTIVE);
  localparam logic [11:0] PadW     = 12'(PADDLE_W);
  localparam logic [11:0] PadLen   = 12'(PADDLE_LEN);
  localparam logic [11:0] BallSide = 12'(BALL_SIDE);

  // Position buffering: shadow holds an accepted update until frame_start
  logic [9:0] p1_q, p1_d, p2_q, p2_d, bx_q, bx_d, by_q, by_d;
  logic [9:0] p1_sh_q, p1_sh_d, p2_sh_q, p2_sh_d, bx_sh_q, bx_sh_d, by_sh_q, by_sh_d;
  logic       pending_q, pending_d;
  logic       accept;

  assign pos_ready = ~pending_q;
  assign accept    = pos_valid & ~pending_q;

  // Next-state for shadow capture and frame-boundary commit
  always_comb begin
    p1_d      = p1_q;
    p2_d      = p2_q;
    bx_d      = bx_q;
    by_d      = by_q;
    p1_sh_d   = p1_sh_q;
    p2_sh_d   = p2_sh_q;
    bx_sh_d   = bx_sh_q;
    by_sh_d   = by_sh_q;
    pending_d = pending_q;
    // accept and commit are exclusive: accept needs pending low, commit needs it high
    if (frame_start && pending_q) begin
      p1_d      = p1_sh_q;
      p2_d      = p2_sh_q;
      bx_d      = bx_sh_q;
      by_d      = by_sh_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      p1_sh_d   = paddle_1;
      p2_sh_d   = paddle_2;
      bx_sh_d   = ball_x;
      by_sh_d   = ball_y;
      pending_d = 1'b1;
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q      <= RstPaddle;
      p2_q      <= RstPaddle;
      bx_q      <= RstBallX;
      by_q      <= RstBallY;
      p1_sh_q   <= '0;
      p2_sh_q   <= '0;
      bx_sh_q   <= '0;
      by_sh_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      p1_sh_q   <= p1_sh_d;
      p2_sh_q   <= p2_sh_d;
      bx_sh_q   <= bx_sh_d;
      by_sh_q   <= by_sh_d;
      pending_q <= pending_d;
    end
  end

  logic flash_on;

`ifdef PONG_GOAL_FLASH_EN
  localparam int unsigned FlashW = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

  logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;

  // Goal (re)loads the count; each frame_start burns one frame
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (goal) begin
      flash_cnt_d = FlashW'(FLASH_FRAMES);
    end else if (frame_start && (flash_cnt_q != '0)) begin
      flash_cnt_d = flash_cnt_q - FlashW'(1);
    end
  end

  // Flash frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt_q <= '0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign flash_on = (flash_cnt_q != '0);
`else
  logic                 unused_goal;
  localparam int unsigned UnusedFlashFrames = FLASH_FRAMES;

  assign unused_goal = goal;
  assign flash_on    = 1'b0;
`endif

  // Object hit tests against the currently active positions
  logic ball_hit, lpad_hit, rpad_hit, net_hit, border_hit;

  pong_rect_hit u_ball (
    .x   (h_cnt),
    .y   (v_cnt),
    .x0  (HOfs + {2'b00, bx_q}),
    .y0  (VOfs + {2'b00, by_q}),
    .w   (BallSide),
    .h   (BallSide),
    .hit (ball_hit)
  );

  pong_rect_hit u_lpad (
    .x   (h_cnt),
    .y   (v_cnt),
    .x0  (LPadX),
    .y0  (VOfs + {2'b00, p1_q}),
    .w   (PadW),
    .h   (PadLen),
    .hit (lpad_hit)
  );

  pong_rect_hit u_rpad (
    .x   (h_cnt),
    .y   (v_cnt),
    .x0  (RPadX),
    .y0  (VOfs + {2'b00, p2_q}),
    .w   (PadW),
    .h   (PadLen),
    .hit (rpad_hit)
  );

  pong_rect_hit u_net (
    .x   (h_cnt),
    .y   (v_cnt),
    .x0  (NetX),
    .y0  (VOfs),
    .w   (NetW),
    .h   (VAct),
    .hit (net_hit)
  );

  // Border: inside the active area but outside the inset rectangle
  always_comb begin
    border_hit = (h_cnt >= XLo) && (h_cnt < XHi) && (v_cnt >= YLo) && (v_cnt < YHi) &&
                 !((h_cnt >= XInLo) && (h_cnt < XInHi) && (v_cnt >= YInLo) && (v_cnt < YInHi));
  end

  // Stage 1: register hit flags, flash state and enable
  logic ball_q, paddle_q, border_q, net_q, flash_q, en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_q   <= 1'b0;
      paddle_q <= 1'b0;
      border_q <= 1'b0;
      net_q    <= 1'b0;
      flash_q  <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      ball_q   <= ball_hit;
      paddle_q <= lpad_hit | rpad_hit;
      border_q <= border_hit;
      net_q    <= net_hit;
      flash_q  <= flash_on;
      en_q     <= enable;
    end
  end

  // Priority colour select; border shares the net's class but owns the flash colour
  rgb12_t rgb_d, rgb_q;
  logic   pix_valid_q;

  always_comb begin
    rgb_d = '0;
    if (en_q) begin
      if (ball_q) begin
        rgb_d = COL_BALL;
      end else if (paddle_q) begin
        rgb_d = COL_FG;
      end else if (border_q) begin
        rgb_d = flash_q ? COL_FLASH : COL_FG;
      end else if (net_q) begin
        rgb_d = COL_FG;
      end
    end
  end

  // Stage 2: register colour and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      pix_valid_q <= en_q;
    end
  end

  assign red       = rgb_r(rgb_q);
  assign green     = rgb_g(rgb_q);
  assign blue      = rgb_b(rgb_q);
  assign pix_valid = pix_valid_q;

endmodule
